// File: rtl/serv_mtimer.sv
// RISC-V machine timer (mtime/mtimecmp) as a single-cycle-ack Wishbone slave for SERV.
// Optional prescaler enabled by defining SERV_MTIMER_PRESCALE_EN (PRESCALE clocks per tick).
module serv_mtimer #(
  parameter int unsigned PRESCALE = 16
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_wb_cyc,
  input  logic        i_wb_we,
  input  logic [1:0]  i_wb_adr,
  input  logic [31:0] i_wb_dat,
  input  logic [3:0]  i_wb_sel,
  output logic [31:0] o_wb_rdt,
  output logic        o_wb_ack,
  output logic        o_timer_irq
);

  localparam logic [1:0] ADR_MTIME_LO = 2'd0;
  localparam logic [1:0] ADR_MTIME_HI = 2'd1;
  localparam logic [1:0] ADR_CMP_LO   = 2'd2;
  localparam logic [1:0] ADR_CMP_HI   = 2'd3;

  // Legal prescale range, checked at elaboration in every build.
  if ((PRESCALE < 32'd2) || (PRESCALE > 32'd65535)) begin : g_prescale_range
    $error("serv_mtimer: PRESCALE out of range 2..65535");
  end

  function automatic logic [31:0] merge_bytes(
    input logic [31:0] old_v,
    input logic [31:0] new_v,
    input logic [3:0]  sel
  );
    logic [31:0] res;
    res = old_v;
    for (int b = 0; b < 4; b++) begin
      if (sel[b]) begin
        res[8*b +: 8] = new_v[8*b +: 8];
      end else begin
        res[8*b +: 8] = old_v[8*b +: 8];
      end
    end
    return res;
  endfunction

  logic [63:0] mtime_r;
  logic [63:0] mtimecmp_r;
  logic [31:0] hi_shadow_r;
  logic [31:0] rdt_r;
  logic        ack_r;
  logic        irq_r;

  logic        tick_s;
  logic        start_s;
  logic [63:0] mtime_inc_s;
  logic [63:0] mtime_nxt_s;
  logic [63:0] mtimecmp_nxt_s;
  logic [31:0] hi_shadow_nxt_s;
  logic [31:0] rdt_nxt_s;

`ifdef SERV_MTIMER_PRESCALE_EN
  localparam logic [15:0] PRESCALE_RELOAD = 16'(PRESCALE - 32'd1);

  logic [15:0] presc_r;

  // Prescale down-counter: tick on zero, then reload.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      presc_r <= 16'd0;
    end else if (presc_r == 16'd0) begin
      presc_r <= PRESCALE_RELOAD;
    end else begin
      presc_r <= presc_r - 16'd1;
    end
  end

  assign tick_s = (presc_r == 16'd0);
`else
  assign tick_s = 1'b1;
`endif

  // Bus decode and next-state for timer registers, shadow and read data.
  always_comb begin
    start_s         = i_wb_cyc & ~ack_r;
    mtime_inc_s     = tick_s ? (mtime_r + 64'd1) : mtime_r;
    mtime_nxt_s     = mtime_inc_s;
    mtimecmp_nxt_s  = mtimecmp_r;
    hi_shadow_nxt_s = hi_shadow_r;
    rdt_nxt_s       = 32'd0;
    if (start_s && i_wb_we) begin
      // Unwritten mtime bytes keep the incremented value of this same edge.
      case (i_wb_adr)
        ADR_MTIME_LO: mtime_nxt_s[31:0]     = merge_bytes(mtime_inc_s[31:0], i_wb_dat, i_wb_sel);
        ADR_MTIME_HI: mtime_nxt_s[63:32]    = merge_bytes(mtime_inc_s[63:32], i_wb_dat, i_wb_sel);
        ADR_CMP_LO:   mtimecmp_nxt_s[31:0]  = merge_bytes(mtimecmp_r[31:0], i_wb_dat, i_wb_sel);
        ADR_CMP_HI:   mtimecmp_nxt_s[63:32] = merge_bytes(mtimecmp_r[63:32], i_wb_dat, i_wb_sel);
        default:      mtime_nxt_s           = mtime_inc_s;
      endcase
    end else if (start_s) begin
      case (i_wb_adr)
        ADR_MTIME_LO: begin
          rdt_nxt_s       = mtime_r[31:0];
          hi_shadow_nxt_s = mtime_r[63:32];
        end
        ADR_MTIME_HI: rdt_nxt_s = hi_shadow_r;
        ADR_CMP_LO:   rdt_nxt_s = mtimecmp_r[31:0];
        ADR_CMP_HI:   rdt_nxt_s = mtimecmp_r[63:32];
        default:      rdt_nxt_s = 32'd0;
      endcase
    end else begin
      rdt_nxt_s = 32'd0;
    end
  end

  // Timer state, bus response and interrupt registers.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      mtime_r     <= 64'd0;
      mtimecmp_r  <= 64'hFFFF_FFFF_FFFF_FFFF;
      hi_shadow_r <= 32'd0;
      rdt_r       <= 32'd0;
      ack_r       <= 1'b0;
      irq_r       <= 1'b0;
    end else begin
      mtime_r     <= mtime_nxt_s;
      mtimecmp_r  <= mtimecmp_nxt_s;
      hi_shadow_r <= hi_shadow_nxt_s;
      rdt_r       <= rdt_nxt_s;
      ack_r       <= start_s;
      irq_r       <= (mtime_r >= mtimecmp_r);
    end
  end

  assign o_wb_rdt    = rdt_r;
  assign o_wb_ack    = ack_r;
  assign o_timer_irq = irq_r;

endmodule

// File: tb/tb_serv_mtimer.sv
// Randomised self-checking bench for serv_mtimer (default build, one tick per clock)
// against a cycle-level arithmetic reference model of the timer registers.
module tb_serv_mtimer;

  logic        clk;
  logic        rst_n;
  logic        cyc;
  logic        we;
  logic [1:0]  adr;
  logic [31:0] dat;
  logic [3:0]  sel;
  logic [31:0] rdt;
  logic        ack;
  logic        irq;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  logic [63:0] m_mtime;
  logic [63:0] m_cmp;
  logic [31:0] m_shadow;
  logic [31:0] m_rdt;
  logic        m_ack;
  logic        m_irq;

  serv_mtimer dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_wb_cyc    (cyc),
    .i_wb_we     (we),
    .i_wb_adr    (adr),
    .i_wb_dat    (dat),
    .i_wb_sel    (sel),
    .o_wb_rdt    (rdt),
    .o_wb_ack    (ack),
    .o_timer_irq (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_mtime  = 64'd0;
    m_cmp    = 64'hFFFF_FFFF_FFFF_FFFF;
    m_shadow = 32'd0;
    m_rdt    = 32'd0;
    m_ack    = 1'b0;
    m_irq    = 1'b0;
  endtask

  // One clock: advance the model from the inputs seen at the edge, then compare.
  task automatic cycle();
    logic [63:0] nt;
    logic [63:0] ncmp;
    logic [31:0] nshadow;
    logic [31:0] nrdt;
    logic        start;
    int          off;
    @(posedge clk);
    start   = cyc && !m_ack;
    nt      = m_mtime + 64'd1;
    ncmp    = m_cmp;
    nshadow = m_shadow;
    nrdt    = 32'd0;
    off     = (adr[0] == 1'b1) ? 32 : 0;
    if (start && we) begin
      for (int b = 0; b < 4; b++) begin
        if (sel[b]) begin
          if (adr[1] == 1'b0) nt[off + 8*b +: 8] = dat[8*b +: 8];
          else ncmp[off + 8*b +: 8] = dat[8*b +: 8];
        end
      end
    end else if (start) begin
      case (adr)
        2'd0: begin nrdt = m_mtime[31:0]; nshadow = m_mtime[63:32]; end
        2'd1: nrdt = m_shadow;
        2'd2: nrdt = m_cmp[31:0];
        default: nrdt = m_cmp[63:32];
      endcase
    end
    m_irq    = (m_mtime >= m_cmp);
    m_mtime  = nt;
    m_cmp    = ncmp;
    m_shadow = nshadow;
    m_rdt    = nrdt;
    m_ack    = start;
    #1;
    check_eq("ack", {63'd0, ack}, {63'd0, m_ack});
    check_eq("irq", {63'd0, irq}, {63'd0, m_irq});
    if (m_ack) check_eq("rdt", {32'd0, rdt}, {32'd0, m_rdt});
  endtask

  task automatic idle(input int n);
    cyc = 1'b0;
    repeat (n) cycle();
  endtask

  task automatic bus(input logic w, input logic [1:0] a, input logic [31:0] d,
                     input logic [3:0] s, output logic [31:0] rd);
    cyc = 1'b1; we = w; adr = a; dat = d; sel = s;
    cycle();
    rd  = rdt;
    cyc = 1'b0;
    cycle();
  endtask

  // Async reset applied away from the clock edge, released at a falling edge.
  task automatic pulse_reset();
    rst_n = 1'b0;
    #1;
    check_eq("rst_ack", {63'd0, ack}, 64'd0);
    check_eq("rst_irq", {63'd0, irq}, 64'd0);
    check_eq("rst_rdt", {32'd0, rdt}, 64'd0);
    model_reset();
    cyc = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    logic [31:0] rd;
    logic        ack_pat [6];
    int          waited;
    ack_pat = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    rst_n = 1'b0; cyc = 1'b0; we = 1'b0; adr = 2'd0; dat = 32'd0; sel = 4'd0;
    model_reset();
    #12;
    pulse_reset();

    // Free-running count after reset
    idle(10);
    bus(1'b0, 2'd0, 32'd0, 4'hF, rd);
    check_eq("mtime_lo_after_10", {32'd0, rd}, 64'd10);
    check_eq("irq_idle", {63'd0, irq}, 64'd0);

    // Compare match raises irq and holds it
    bus(1'b1, 2'd3, 32'd0, 4'hF, rd);
    bus(1'b1, 2'd2, 32'd20, 4'hF, rd);
    waited = 0;
    while (!irq && waited < 40) begin cycle(); waited++; end
    check_eq("irq_raised", {63'd0, irq}, 64'd1);
    idle(3);
    check_eq("irq_held", {63'd0, irq}, 64'd1);

    // Raising compare drops irq one cycle after the write
    bus(1'b1, 2'd2, 32'hFFFF_FFFF, 4'hF, rd);
    check_eq("irq_cleared", {63'd0, irq}, 64'd0);

    // Async reset during an ack
    bus(1'b1, 2'd2, 32'd20, 4'hF, rd);
    idle(1);
    cyc = 1'b1; we = 1'b0; adr = 2'd0;
    cycle();
    check_eq("ack_before_rst", {63'd0, ack}, 64'd1);
    pulse_reset();

    // Byte-lane write into reset compare value
    bus(1'b1, 2'd2, 32'hAABB_CCDD, 4'b0010, rd);
    bus(1'b0, 2'd2, 32'd0, 4'hF, rd);
    check_eq("cmp_lo_bytelane", {32'd0, rd}, 64'hFFFF_CCFF);
    bus(1'b1, 2'd3, 32'h1234_5678, 4'b0000, rd);
    bus(1'b0, 2'd3, 32'd0, 4'hF, rd);
    check_eq("cmp_hi_sel0", {32'd0, rd}, 64'hFFFF_FFFF);

    // Held cyc acks every other cycle
    cyc = 1'b1; we = 1'b0; adr = 2'd2;
    for (int i = 0; i < 6; i++) begin
      check_eq("ack_pattern", {63'd0, ack}, {63'd0, ack_pat[i]});
      cycle();
    end
    idle(1);

    // 64-bit wrap
    bus(1'b1, 2'd1, 32'hFFFF_FFFF, 4'hF, rd);
    bus(1'b1, 2'd0, 32'hFFFF_FFFE, 4'hF, rd);
    idle(1);
    bus(1'b0, 2'd0, 32'd0, 4'hF, rd);
    check_eq("wrap_lo", {32'd0, rd}, 64'd0);
    bus(1'b0, 2'd1, 32'd0, 4'hF, rd);
    check_eq("wrap_hi", {32'd0, rd}, 64'd0);

    // Coherent lo-then-hi read across a carry
    bus(1'b1, 2'd1, 32'd1, 4'hF, rd);
    bus(1'b1, 2'd0, 32'hFFFF_FFFD, 4'hF, rd);
    idle(1);
    bus(1'b0, 2'd0, 32'd0, 4'hF, rd);
    check_eq("coh_lo", {32'd0, rd}, 64'hFFFF_FFFF);
    bus(1'b0, 2'd1, 32'd0, 4'hF, rd);
    check_eq("coh_hi_shadow", {32'd0, rd}, 64'd1);

    // Randomised traffic
    for (int k = 0; k < 4000; k++) begin
      cyc = ($urandom_range(0, 2) == 0);
      we  = $urandom_range(0, 1) == 1;
      adr = 2'($urandom_range(0, 3));
      sel = ($urandom_range(0, 2) == 0) ? 4'($urandom_range(0, 15)) : 4'hF;
      case ($urandom_range(0, 3))
        0: dat = m_mtime[31:0] + 32'($urandom_range(0, 12));
        1: dat = m_mtime[63:32] + 32'($urandom_range(0, 1));
        default: dat = $urandom;
      endcase
      cycle();
      if ($urandom_range(0, 799) == 0) pulse_reset();
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
